input_spike_encoder: RTL and testbench
======================================

INPUT_SPIKE_ENCODER -- requirements
Module: input_spike_encoder

Interface
REQ-001 Parameter data_bit, default 7: sample MSB index; sample width is data_bit+1.
REQ-002 Parameter thr_shift, default 3: encoding threshold THR = 2^thr_shift.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port resetn, input, 1: reset, asynchronous and active-high despite the name.
REQ-005 Port sample_in, input, data_bit+1: unsigned ECG sample.
REQ-006 Port sample_valid, input, 1: sample_in is valid this cycle.
REQ-007 Port sample_ready, output, 1: encoder accepts a sample on an edge where valid and ready are both high.
REQ-008 Port spikes_out, output, 16: per-channel spike request, held high until acknowledged.
REQ-009 Port acks_in, input, 16: per-channel acknowledge from the hidden-layer neuron arbiter.
REQ-010 Ports addr_out00 to addr_out15, output, 4 each: per-channel weight index, stable while the matching spikes_out bit is high.

Function
REQ-011 FSM states: IDLE, ENCODE, EMIT; sample_ready is high only in IDLE.
REQ-012 IDLE: on accept, latch the sample, go to ENCODE, and increment the 4-bit time-bin counter, which wraps 15 to 0.
REQ-013 ENCODE (one cycle): compute delta = sample - ref as signed data_bit+2 bits; mag = |delta|; then set ref to the sample.
REQ-014 If mag < THR, no event; next state IDLE.
REQ-015 If mag >= THR, bucket = min((mag >> thr_shift) - 1, 7); channel = bucket when delta > 0, else 8 + bucket; next state EMIT.
REQ-016 EMIT (one cycle): post the event to the selected channel with addr = time-bin value at acceptance; next state IDLE.
REQ-017 Latency: the spikes_out bit rises at most 3 edges after the accept edge, when the channel is idle.
REQ-018 Each channel holds one active request plus a 1-deep pending slot; each slot stores its own addr.
REQ-019 Event to an idle channel: raise spikes_out[k] and drive addr_out[k] on the next edge.
REQ-020 Event to an active channel with an empty pending slot: store the event in the pending slot.
REQ-021 Event to an active channel with a full pending slot: drop the event.
REQ-022 acks_in[k] sampled high while spikes_out[k] is high: clear spikes_out[k] on that edge.
REQ-023 After clearing, spikes_out[k] stays low for at least one full cycle, then a pending event is raised with its stored addr.
REQ-024 acks_in[k] high while spikes_out[k] is low: ignored.
REQ-025 Ack and new event for the same channel on the same edge: the ack is processed first, then the new event follows REQ-019 to REQ-021.
REQ-026 Channels are independent; any number may be active at once.

Reset
REQ-027 While resetn is high, the block asynchronously holds: state IDLE, spikes_out 0, all addr_out 0, pending slots empty, ref 0, time-bin counter 0, primed flag 0, drop_cnt 0.
REQ-028 The first accepted sample after reset only loads ref and sets the primed flag; it emits no event.
REQ-029 Reset mid-handshake clears all requests immediately; acks that arrive after reset are ignored.

Configuration
REQ-030 Macro SPIKE_DROP_CNT_EN defined: add output drop_cnt, 8 bits, incremented once per dropped event and saturating at 255.
REQ-031 Macro SPIKE_DROP_CNT_EN undefined: no drop_cnt port; drops are silent; all other behaviour is identical.

Verification
REQ-032 Reset, then samples 100 and 100 -> no spikes_out activity; sample_ready returns high.
REQ-033 Primed ref 100, sample 120 (THR 8): mag 20, bucket 1 -> spikes_out[1] high with addr_out01 = 2; hold ack low 10 cycles -> request and addr stable; ack -> bit clears.
REQ-034 Ref 200, sample 50 -> mag 150, bucket clamps to 7 -> spikes_out[15] asserted.
REQ-035 Three events to channel 0 with no ack -> first active, second pending, third dropped; drop_cnt = 1 when the macro is set; ack -> low one cycle, then the pending event is raised with its own addr.
REQ-036 Ack and new event to channel 3 on the same edge -> bit low one cycle, then high again with the new addr.
REQ-037 Assert resetn while spikes_out = 16'h0102 -> immediately 0; the next sample is treated as the first (no spike).

Source files
------------

// File: rtl/input_spike_encoder.sv
// Delta-modulation spike encoder: turns ECG sample deltas into per-channel spike requests
// with a request/ack handshake. Define SPIKE_DROP_CNT_EN to add the saturating drop_cnt output.
module input_spike_encoder #(
   parameter int data_bit  = 7,
   parameter int thr_shift = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [data_bit:0] sample_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   output logic [15:0]       spikes_out,
   input  logic [15:0]       acks_in,
   output logic [3:0]        addr_out00,
   output logic [3:0]        addr_out01,
   output logic [3:0]        addr_out02,
   output logic [3:0]        addr_out03,
   output logic [3:0]        addr_out04,
   output logic [3:0]        addr_out05,
   output logic [3:0]        addr_out06,
   output logic [3:0]        addr_out07,
   output logic [3:0]        addr_out08,
   output logic [3:0]        addr_out09,
   output logic [3:0]        addr_out10,
   output logic [3:0]        addr_out11,
   output logic [3:0]        addr_out12,
   output logic [3:0]        addr_out13,
   output logic [3:0]        addr_out14,
   output logic [3:0]        addr_out15
`ifdef SPIKE_DROP_CNT_EN
   ,
   output logic [7:0]        drop_cnt
`endif
);

   // state  | meaning
   // IDLE   | waiting for a sample, sample_ready high
   // ENCODE | compare latched sample against ref, pick channel
   // EMIT   | post the event to the selected channel
   typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_EMIT} state_t;

   localparam int SW = data_bit + 2;

   state_t            state;
   logic [data_bit:0] sample_q;
   logic [data_bit:0] ref_q;
   logic [3:0]        tbin;
   logic [3:0]        tag_q;
   logic              primed;
   logic [3:0]        ev_ch;
   logic [3:0]        ev_addr;

   logic [SW-1:0]     delta;
   logic [SW-1:0]     mag;
   logic [SW-1:0]     mag_sh;
   logic [2:0]        bucket;
   logic              hit;
   logic              ev_fire;

   logic [15:0]       active, gap, pend;
   logic [15:0]       active_nx, gap_nx, pend_nx;
   logic [3:0]        addr_q   [16];
   logic [3:0]        paddr_q  [16];
   logic [3:0]        addr_nx  [16];
   logic [3:0]        paddr_nx [16];
`ifdef SPIKE_DROP_CNT_EN
   logic              drop_ev;
`endif

   assign delta  = {1'b0, sample_q} - {1'b0, ref_q};
   assign mag    = delta[SW-1] ? (SW'(0) - delta) : delta;
   assign mag_sh = mag >> thr_shift;
   assign hit    = (mag_sh != '0);
   assign bucket = (mag_sh > SW'(8)) ? 3'd7 : 3'(mag_sh - SW'(1));

   assign sample_ready = (state == S_IDLE);
   assign ev_fire      = (state == S_EMIT);

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state    <= S_IDLE;
         sample_q <= '0;
         ref_q    <= '0;
         tbin     <= '0;
         tag_q    <= '0;
         primed   <= 1'b0;
         ev_ch    <= '0;
         ev_addr  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (sample_valid) begin
                  sample_q <= sample_in;
                  tbin     <= tbin + 4'd1;
                  tag_q    <= tbin + 4'd1;
                  state    <= S_ENCODE;
               end
            end
            S_ENCODE: begin
               ref_q <= sample_q;
               if (!primed) begin
                  primed <= 1'b1;
                  state  <= S_IDLE;
               end else if (hit) begin
                  ev_ch   <= {delta[SW-1], bucket};
                  ev_addr <= tag_q;
                  state   <= S_EMIT;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_EMIT:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Ack first, then gap release, then the new event sees the resulting channel state.
   always_comb begin
      active_nx = active;
      gap_nx    = gap;
      pend_nx   = pend;
      addr_nx   = addr_q;
      paddr_nx  = paddr_q;
`ifdef SPIKE_DROP_CNT_EN
      drop_ev   = 1'b0;
`endif
      for (int k = 0; k < 16; k++) begin
         if (active[k] && acks_in[k]) begin
            active_nx[k] = 1'b0;
            gap_nx[k]    = 1'b1;
         end else if (gap[k]) begin
            gap_nx[k] = 1'b0;
            if (pend[k]) begin
               active_nx[k] = 1'b1;
               addr_nx[k]   = paddr_q[k];
               pend_nx[k]   = 1'b0;
            end
         end
         if (ev_fire && (ev_ch == 4'(k))) begin
            if (!active_nx[k] && !gap_nx[k]) begin
               active_nx[k] = 1'b1;
               addr_nx[k]   = ev_addr;
            end else if (!pend_nx[k]) begin
               pend_nx[k]  = 1'b1;
               paddr_nx[k] = ev_addr;
            end
`ifdef SPIKE_DROP_CNT_EN
            else begin
               drop_ev = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         active <= '0;
         gap    <= '0;
         pend   <= '0;
         for (int k = 0; k < 16; k++) begin
            addr_q[k]  <= '0;
            paddr_q[k] <= '0;
         end
      end else begin
         active  <= active_nx;
         gap     <= gap_nx;
         pend    <= pend_nx;
         addr_q  <= addr_nx;
         paddr_q <= paddr_nx;
      end
   end

`ifdef SPIKE_DROP_CNT_EN
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn)
         drop_cnt <= '0;
      else if (drop_ev && (drop_cnt != 8'hFF))
         drop_cnt <= drop_cnt + 8'd1;
   end
`endif

   assign spikes_out = active;
   assign addr_out00 = addr_q[0];
   assign addr_out01 = addr_q[1];
   assign addr_out02 = addr_q[2];
   assign addr_out03 = addr_q[3];
   assign addr_out04 = addr_q[4];
   assign addr_out05 = addr_q[5];
   assign addr_out06 = addr_q[6];
   assign addr_out07 = addr_q[7];
   assign addr_out08 = addr_q[8];
   assign addr_out09 = addr_q[9];
   assign addr_out10 = addr_q[10];
   assign addr_out11 = addr_q[11];
   assign addr_out12 = addr_q[12];
   assign addr_out13 = addr_q[13];
   assign addr_out14 = addr_q[14];
   assign addr_out15 = addr_q[15];

endmodule

// File: tb/tb_input_spike_encoder.sv
// Bench for input_spike_encoder: directed scenarios plus random samples/acks against an
// event-level channel model (active + pending queue per channel, one-cycle gap after ack).
module tb_input_spike_encoder;
   localparam int DB  = 7;
   localparam int TS  = 3;
   localparam int THR = 1 << TS;

   logic        clk = 1'b0;
   logic        resetn;
   logic [DB:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic [15:0] spikes_out;
   logic [15:0] acks_in;
   logic [3:0]  addr_out00, addr_out01, addr_out02, addr_out03;
   logic [3:0]  addr_out04, addr_out05, addr_out06, addr_out07;
   logic [3:0]  addr_out08, addr_out09, addr_out10, addr_out11;
   logic [3:0]  addr_out12, addr_out13, addr_out14, addr_out15;
   logic [63:0] addr_vec;
`ifdef SPIKE_DROP_CNT_EN
   logic [7:0]  drop_cnt;
`endif

   always #5 clk = ~clk;

   input_spike_encoder #(.data_bit(DB), .thr_shift(TS)) dut (
      .clk(clk), .resetn(resetn), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .spikes_out(spikes_out), .acks_in(acks_in),
      .addr_out00(addr_out00), .addr_out01(addr_out01), .addr_out02(addr_out02),
      .addr_out03(addr_out03), .addr_out04(addr_out04), .addr_out05(addr_out05),
      .addr_out06(addr_out06), .addr_out07(addr_out07), .addr_out08(addr_out08),
      .addr_out09(addr_out09), .addr_out10(addr_out10), .addr_out11(addr_out11),
      .addr_out12(addr_out12), .addr_out13(addr_out13), .addr_out14(addr_out14),
      .addr_out15(addr_out15)
`ifdef SPIKE_DROP_CNT_EN
      , .drop_cnt(drop_cnt)
`endif
   );

   assign addr_vec = {addr_out15, addr_out14, addr_out13, addr_out12, addr_out11, addr_out10,
                      addr_out09, addr_out08, addr_out07, addr_out06, addr_out05, addr_out04,
                      addr_out03, addr_out02, addr_out01, addr_out00};

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_tbin, m_ref, ev_timer, ev_ch_m, ev_addr_m, busy, m_drops;
   bit m_primed;
   bit m_act [16];
   bit m_gap [16];
   int m_cnt [16];
   int m_slot0 [16];
   int m_slot1 [16];
   bit last_acc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rand_acks();
      return 16'($urandom & $urandom);
   endfunction

   function automatic logic [15:0] exp_spikes();
      logic [15:0] v = '0;
      for (int k = 0; k < 16; k++) v[k] = m_act[k];
      return v;
   endfunction

   function automatic logic [63:0] exp_mask();
      logic [63:0] v = '0;
      for (int k = 0; k < 16; k++) if (m_act[k]) v[k*4 +: 4] = 4'hF;
      return v;
   endfunction

   function automatic logic [63:0] exp_addr();
      logic [63:0] v = '0;
      for (int k = 0; k < 16; k++) if (m_act[k]) v[k*4 +: 4] = 4'(m_slot0[k]);
      return v;
   endfunction

   task automatic model_reset();
      m_tbin = 0; m_ref = 0; m_primed = 0; ev_timer = 0; busy = 0; m_drops = 0;
      ev_ch_m = 0; ev_addr_m = 0; last_acc = 0;
      for (int k = 0; k < 16; k++) begin
         m_act[k] = 0; m_gap[k] = 0; m_cnt[k] = 0; m_slot0[k] = 0; m_slot1[k] = 0;
      end
   endtask

   task automatic model_edge(input bit acc, input logic [15:0] a, input logic [DB:0] s);
      bit due;
      int d, mag, b;
      due = (ev_timer == 1);
      if (ev_timer > 0) ev_timer--;
      if (busy > 0) busy--;
      for (int k = 0; k < 16; k++) begin
         if (m_act[k] && a[k]) begin
            m_act[k] = 0; m_gap[k] = 1;
            m_slot0[k] = m_slot1[k]; m_cnt[k]--;
         end else if (m_gap[k]) begin
            m_gap[k] = 0;
            if (m_cnt[k] > 0) m_act[k] = 1;
         end
         if (due && ev_ch_m == k) begin
            if (m_cnt[k] == 0 && !m_gap[k]) begin
               m_slot0[k] = ev_addr_m; m_cnt[k] = 1; m_act[k] = 1;
            end else if (m_cnt[k] == 0) begin
               m_slot0[k] = ev_addr_m; m_cnt[k] = 1;
            end else if (m_cnt[k] == 1) begin
               m_slot1[k] = ev_addr_m; m_cnt[k] = 2;
            end else if (m_drops < 255) begin
               m_drops++;
            end
         end
      end
      if (acc) begin
         m_tbin = (m_tbin + 1) % 16;
         if (!m_primed) begin
            m_primed = 1; m_ref = int'(s); busy = 1;
         end else begin
            d = int'(s) - m_ref;
            m_ref = int'(s);
            mag = (d < 0) ? -d : d;
            if (mag >= THR) begin
               b = mag / THR - 1;
               if (b > 7) b = 7;
               ev_ch_m   = (d > 0) ? b : 8 + b;
               ev_addr_m = m_tbin;
               ev_timer  = 2;
               busy      = 2;
            end else begin
               busy = 1;
            end
         end
      end
   endtask

   task automatic tick(input logic [15:0] a);
      bit acc;
      logic [DB:0] s;
      acks_in = a;
      acc = sample_valid && sample_ready;
      s = sample_in;
      @(posedge clk);
      #1;
      model_edge(acc, a, s);
      last_acc = acc;
      check("spikes", 64'(spikes_out), 64'(exp_spikes()));
      check("ready", 64'(sample_ready), 64'(busy == 0));
      check("addr", addr_vec & exp_mask(), exp_addr());
`ifdef SPIKE_DROP_CNT_EN
      check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
`endif
   endtask

   task automatic idle(input int n, input bit rnd);
      for (int i = 0; i < n; i++) tick(rnd ? rand_acks() : 16'h0);
   endtask

   task automatic send(input logic [DB:0] s, input bit rnd);
      sample_in = s;
      sample_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(rnd ? rand_acks() : 16'h0);
         if (last_acc) break;
      end
      check("accept", 64'(last_acc), 64'd1);
      sample_valid = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      resetn = 1'b1;
      #1;
      check("rst_spikes", 64'(spikes_out), 64'd0);
      check("rst_addr", addr_vec, 64'd0);
      check("rst_ready", 64'(sample_ready), 64'd1);
      model_reset();
      sample_valid = 1'b0;
      acks_in = 16'h0102;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b0;
   endtask

   initial begin
      resetn = 1'b1;
      sample_in = '0;
      sample_valid = 1'b0;
      acks_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("init_spikes", 64'(spikes_out), 64'd0);
      check("init_ready", 64'(sample_ready), 64'd1);
      resetn = 1'b0;

      // Equal samples: no spike activity
      send(8'd100, 0); send(8'd100, 0); idle(4, 0);
      check("same_no_spike", 64'(spikes_out), 64'd0);
      check("same_ready", 64'(sample_ready), 64'd1);

      // +20 -> channel 1, addr 2, held until ack
      do_reset();
      send(8'd100, 0); send(8'd120, 0); idle(12, 0);
      check("ch1_hold", 64'(spikes_out[1]), 64'd1);
      check("ch1_addr", 64'(addr_out01), 64'd2);
      tick(16'h0002);
      check("ch1_clear", 64'(spikes_out[1]), 64'd0);
      idle(2, 0);

      // Large negative delta clamps to channel 15
      send(8'd200, 0); send(8'd50, 0); idle(3, 0);
      check("clamp_ch15", 64'(spikes_out[15]), 64'd1);
      tick(16'hFFFF); idle(2, 0);

      // Three events to channel 0: active, pending, dropped
      do_reset();
      send(8'd50, 0); send(8'd60, 0); send(8'd70, 0); send(8'd80, 0); idle(3, 0);
      check("ch0_active", 64'(spikes_out[0]), 64'd1);
      check("ch0_addr1", 64'(addr_out00), 64'd2);
`ifdef SPIKE_DROP_CNT_EN
      check("ch0_drop", 64'(drop_cnt), 64'd1);
`endif
      tick(16'h0001);
      check("ch0_gap", 64'(spikes_out[0]), 64'd0);
      tick(16'h0000);
      check("ch0_pend", 64'(spikes_out[0]), 64'd1);
      check("ch0_addr2", 64'(addr_out00), 64'd3);
      tick(16'h0001); idle(2, 0);

      // Ack and new event on channel 3 on the same edge
      send(8'd115, 0); idle(2, 0);
      check("ch3_first", 64'(spikes_out[3]), 64'd1);
      send(8'd150, 0); tick(16'h0000); tick(16'h0008);
      check("ch3_gap", 64'(spikes_out[3]), 64'd0);
      tick(16'h0000);
      check("ch3_new", 64'(spikes_out[3]), 64'd1);
      check("ch3_addr", 64'(addr_out03), 64'd6);
      tick(16'h0008); idle(2, 0);

      // Reset mid-handshake with channels 1 and 8 requesting
      do_reset();
      send(8'd100, 0); send(8'd120, 0); send(8'd110, 0); idle(3, 0);
      check("pre_rst", 64'(spikes_out), 64'h0102);
      do_reset();
      tick(16'h0102);
      send(8'd30, 0); idle(3, 0);
      check("post_rst_prime", 64'(spikes_out), 64'd0);

      // Random samples with random acks
      for (int i = 0; i < 300; i++) begin
         send(8'($urandom_range(0, 255)), 1);
         idle($urandom_range(0, 3), 1);
         if ($urandom_range(0, 59) == 0) do_reset();
      end
      for (int i = 0; i < 6; i++) tick(16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
